fetch_decode: RTL

//   Front end of cpu15, directly upstream of exec. Fetches the 15-bit instruction from

---
 rtl/fetch_decode_pkg.sv | 46 ++++
 rtl/fetch_decode_fd_seq.sv | 105 ++++++++++
 rtl/fetch_decode.sv | 70 +++++++
 3 files changed

// File: rtl/fetch_decode_pkg.sv
// Shared cpu15 front-end definitions: field widths, opcodes, instruction layout, sequencer states.
package fetch_decode_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [3:0] {
    OP_MOV = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_SL  = 4'h5,
    OP_SR  = 4'h6,
    OP_SRA = 4'h7,
    OP_LDL = 4'h8,
    OP_LDH = 4'h9,
    OP_CMP = 4'hA,
    OP_JE  = 4'hB,
    OP_JMP = 4'hC,
    OP_LD  = 4'hD,
    OP_ST  = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // Instruction word: [14:11] op, [10:8] regA, [7:5] regB, [4:0] low immediate bits.
  // The 8-bit immediate/address is {rb, imm_lo}.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [4:0]       imm_lo;
  } insn_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } fd_state_e;

endpackage

// File: rtl/fetch_decode_fd_seq.sv
// Instruction sequencer: FETCH->DECODE->EXEC->WB FSM, ROM latency wait counter, EX/WB strobes.
// Optional SINGLE_STEP_EN: one instruction per rising edge of step.
module fetch_decode_fd_seq
  import fetch_decode_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
`ifdef SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic [PC_W-1:0] p_count,
  input  logic [OP_W-1:0] op_code,
  output logic [PC_W-1:0] rom_addr,
  output logic            ex_en,
  output logic            wb_en,
  output logic            halted,
  output logic            ir_load_c,
  output logic            retire_c
);

  localparam int unsigned WAIT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ROM_LAT - 1);

  fd_state_e         state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              start_c;
  logic              cont_c;

`ifdef SINGLE_STEP_EN
  logic step_q;

  // Registered copy of step for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step;
  end

  assign start_c = run & step & ~step_q;
  assign cont_c  = 1'b0;
`else
  assign start_c = run;
  assign cont_c  = run;
`endif

  // Strobe the IR capture on the final ROM wait cycle; retire on EXEC->WB or on HLT decode
  assign ir_load_c = (state == ST_FETCH) && (wait_cnt == WAIT_LAST);
  assign retire_c  = (state == ST_EXEC) || ((state == ST_DECODE) && (op_code == OP_HLT));

  // Sequencer FSM with registered address, strobes and halt flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      rom_addr <= '0;
      ex_en    <= 1'b0;
      wb_en    <= 1'b0;
      halted   <= 1'b0;
    end else begin
      ex_en <= 1'b0;
      wb_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_c) begin
            state    <= ST_FETCH;
            wait_cnt <= '0;
            rom_addr <= p_count;
          end
        end
        ST_FETCH: begin
          if (wait_cnt == WAIT_LAST) state    <= ST_DECODE;
          else                       wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        ST_DECODE: begin
          if (op_code == OP_HLT) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            state <= ST_EXEC;
            ex_en <= 1'b1;
          end
        end
        ST_EXEC: begin
          state <= ST_WB;
          wb_en <= 1'b1;
        end
        ST_WB: begin
          if (cont_c) begin
            state    <= ST_FETCH;
            wait_cnt <= '0;
            rom_addr <= p_count;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fetch_decode.sv
// cpu15 fetch/decode front end: IR capture, field split and retired-instruction counter.
// Optional macro SINGLE_STEP_EN adds the step input (one instruction per step pulse).
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSN_W  = 15,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic [PC_W-1:0]   p_count,
  output logic [PC_W-1:0]   rom_addr,
  input  logic [INSN_W-1:0] rom_data,
  output logic [OP_W-1:0]   op_code,
  output logic [REG_W-1:0]  op_a,
  output logic [REG_W-1:0]  op_b,
  output logic [DATA_W-1:0] op_data,
  output logic              ex_en,
  output logic              wb_en,
  output logic              halted,
  output logic [CNT_W-1:0]  insn_cnt
);

  insn_t ir;
  logic  ir_load_c;
  logic  retire_c;

  fetch_decode_fd_seq #(
    .PC_W    (PC_W),
    .ROM_LAT (ROM_LAT)
  ) u_seq (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
`ifdef SINGLE_STEP_EN
    .step      (step),
`endif
    .p_count   (p_count),
    .op_code   (ir.op),
    .rom_addr  (rom_addr),
    .ex_en     (ex_en),
    .wb_en     (wb_en),
    .halted    (halted),
    .ir_load_c (ir_load_c),
    .retire_c  (retire_c)
  );

  // Instruction register, loaded once per fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          ir <= '0;
    else if (ir_load_c) ir <= insn_t'(rom_data);
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         insn_cnt <= '0;
    else if (retire_c) insn_cnt <= insn_cnt + CNT_W'(1);
  end

  assign op_code = ir.op;
  assign op_a    = ir.ra;
  assign op_b    = ir.rb;
  assign op_data = {ir.rb, ir.imm_lo};

endmodule
